// File: rtl/model_scalar_integer_divider_iterative_if.sv
// Handshake and data bundle between a divider requester (master) and the
// iterative divider (slave).
interface model_scalar_integer_divider_iterative_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 SIGNED_MODE;
  logic [DATA_SIZE-1:0] DATA_A_IN;
  logic [DATA_SIZE-1:0] DATA_B_IN;
  logic                 READY;
  logic                 BUSY;
  logic [DATA_SIZE-1:0] DATA_OUT;
  logic [DATA_SIZE-1:0] REMAINDER_OUT;
  logic                 OVERFLOW_OUT;

  modport master (
    output START, SIGNED_MODE, DATA_A_IN, DATA_B_IN,
    input  READY, BUSY, DATA_OUT, REMAINDER_OUT, OVERFLOW_OUT
  );

  modport slave (
    input  START, SIGNED_MODE, DATA_A_IN, DATA_B_IN,
    output READY, BUSY, DATA_OUT, REMAINDER_OUT, OVERFLOW_OUT
  );
endinterface

// File: rtl/model_scalar_integer_divider_iterative.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, signed or
// unsigned, with divide-by-zero and signed-overflow reporting.
module model_scalar_integer_divider_iterative #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4
) (
  input logic CLK,
  input logic RST,
  model_scalar_integer_divider_iterative_if.slave bus
);

  // CONTROL_SIZE is reserved for library uniformity; it has no effect on width.
  localparam int CNT_W = $clog2(DATA_SIZE) + 0 * CONTROL_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] opa_q, opa_d;
  logic [DATA_SIZE-1:0] opb_q, opb_d;
  logic [DATA_SIZE-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic [DATA_SIZE-1:0] rout_q, rout_d;

  logic                 a_neg;
  logic                 b_neg;
  logic [DATA_SIZE:0]   trial;

  function automatic logic [DATA_SIZE-1:0] cond_neg(input logic [DATA_SIZE-1:0] v,
                                                    input logic             neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    sgn_d      = sgn_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    dout_d     = dout_q;
    rout_d     = rout_q;
    ready_d    = 1'b0;
    ovf_d      = 1'b0;

    a_neg = sgn_q & opa_q[DATA_SIZE-1];
    b_neg = sgn_q & opb_q[DATA_SIZE-1];
    // During ITERATE opa_q holds the unconsumed dividend bits in its upper part
    // and the quotient bits collected so far in its lower part.
    trial = {rem_q, opa_q[DATA_SIZE-1]} - {1'b0, opb_q};

    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          opa_d   = bus.DATA_A_IN;
          opb_d   = bus.DATA_B_IN;
          sgn_d   = bus.SIGNED_MODE;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (opb_q == '0) begin
          dout_d  = '1;
          rout_d  = opa_q;
          ovf_d   = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          opa_d      = cond_neg(opa_q, a_neg);
          opb_d      = cond_neg(opb_q, b_neg);
          qneg_d     = a_neg ^ b_neg;
          rneg_d     = a_neg;
          ovf_pend_d = sgn_q && (opa_q == {1'b1, {(DATA_SIZE-1){1'b0}}}) && (opb_q == '1);
          rem_d      = '0;
          cnt_d      = CNT_W'(DATA_SIZE - 1);
          state_d    = S_ITER;
        end
      end

      S_ITER: begin
        if (!trial[DATA_SIZE]) begin
          rem_d = trial[DATA_SIZE-1:0];
          opa_d = {opa_q[DATA_SIZE-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[DATA_SIZE-2:0], opa_q[DATA_SIZE-1]};
          opa_d = {opa_q[DATA_SIZE-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        // Most-negative / -1 already yields the most-negative magnitude unnegated.
        dout_d  = cond_neg(opa_q, qneg_q);
        rout_d  = cond_neg(rem_q, rneg_q);
        ovf_d   = ovf_pend_q;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      sgn_q      <= 1'b0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      dout_q     <= '0;
      rout_q     <= '0;
    end else begin
      state_q    <= state_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      sgn_q      <= sgn_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      ovf_pend_q <= ovf_pend_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      dout_q     <= dout_d;
      rout_q     <= rout_d;
    end
  end

  assign bus.READY         = ready_q;
  assign bus.BUSY          = busy_q;
  assign bus.OVERFLOW_OUT  = ovf_q;
  assign bus.DATA_OUT      = dout_q;
  assign bus.REMAINDER_OUT = rout_q;

endmodule

// File: tb/tb_model_scalar_integer_divider_iterative.sv
// Randomised and directed bench for the iterative divider, checked every cycle
// against an arithmetic reference of the handshake and the division result.
module tb_model_scalar_integer_divider_iterative;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         o;
  } res_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  model_scalar_integer_divider_iterative_if #(.DATA_SIZE(W)) bus ();

  model_scalar_integer_divider_iterative #(.DATA_SIZE(W), .CONTROL_SIZE(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference result straight from the arithmetic definition of division.
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    res_t   r;
    longint sa;
    longint sb;
    if (b == '0) begin
      r.q = '1;
      r.r = a;
      r.o = 1'b1;
    end else if (!sm) begin
      r.q = a / b;
      r.r = a % b;
      r.o = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa == -(longint'(1) <<< (W - 1)) && sb == -1) begin
        r.q = a;
        r.r = '0;
        r.o = 1'b1;
      end else begin
        r.q = W'(sa / sb);
        r.r = W'(sa % sb);
        r.o = 1'b0;
      end
    end
    return r;
  endfunction

  // Expected observable state, advanced once per rising edge.
  int           ecnt      = 0;
  int           m_done    = 0;
  logic         m_busy    = 1'b0;
  res_t         m_res     = '0;
  logic         exp_ready = 1'b0;
  logic         exp_ovf   = 1'b0;
  logic [W-1:0] exp_dout  = '0;
  logic [W-1:0] exp_rem   = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy    <= 1'b0;
      exp_ready <= 1'b0;
      exp_ovf   <= 1'b0;
      exp_dout  <= '0;
      exp_rem   <= '0;
    end else begin
      ecnt      <= ecnt + 1;
      exp_ready <= 1'b0;
      exp_ovf   <= 1'b0;
      if (m_busy) begin
        if (ecnt == m_done) begin
          m_busy    <= 1'b0;
          exp_ready <= 1'b1;
          exp_ovf   <= m_res.o;
          exp_dout  <= m_res.q;
          exp_rem   <= m_res.r;
        end
      end else if (bus.START) begin
        m_res  <= ref_div(bus.DATA_A_IN, bus.DATA_B_IN, bus.SIGNED_MODE);
        m_busy <= 1'b1;
        m_done <= ecnt + ((bus.DATA_B_IN == '0) ? 1 : W + 2);
      end
    end
  end

  always @(negedge CLK) begin
    chk("ready", W'(bus.READY), W'(exp_ready));
    chk("busy", W'(bus.BUSY), W'(m_busy));
    chk("overflow", W'(bus.OVERFLOW_OUT), W'(exp_ovf));
    chk("quotient", bus.DATA_OUT, exp_dout);
    chk("remainder", bus.REMAINDER_OUT, exp_rem);
  end

  // Directed operation from idle; operands are scrambled right after acceptance.
  task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sm, input int lat, input logic [W-1:0] eq,
                    input logic [W-1:0] er, input logic eo);
    int   n;
    logic busy_ok;
    bus.START       = 1'b1;
    bus.DATA_A_IN   = a;
    bus.DATA_B_IN   = b;
    bus.SIGNED_MODE = sm;
    @(posedge CLK); #1;
    bus.START       = 1'b0;
    bus.DATA_A_IN   = W'($urandom);
    bus.DATA_B_IN   = W'($urandom);
    bus.SIGNED_MODE = 1'($urandom);
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.READY && n < 40) begin
      if (!bus.BUSY) busy_ok = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    chk({nm, "_latency"}, W'(n), W'(lat));
    chk({nm, "_busy_span"}, W'(busy_ok), W'(1));
    chk({nm, "_q"}, bus.DATA_OUT, eq);
    chk({nm, "_r"}, bus.REMAINDER_OUT, er);
    chk({nm, "_ovf"}, W'(bus.OVERFLOW_OUT), W'(eo));
    chk({nm, "_busy_at_ready"}, W'(bus.BUSY), W'(0));
    @(posedge CLK); #1;
    chk({nm, "_ovf_cleared"}, W'(bus.OVERFLOW_OUT), W'(0));
    chk({nm, "_ready_pulse"}, W'(bus.READY), W'(0));
  endtask

  initial begin
    int n;
    bus.START       = 1'b0;
    bus.SIGNED_MODE = 1'b0;
    bus.DATA_A_IN   = '0;
    bus.DATA_B_IN   = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ready", W'(bus.READY), W'(0));
    chk("reset_busy", W'(bus.BUSY), W'(0));
    chk("reset_q", bus.DATA_OUT, W'(0));
    chk("reset_r", bus.REMAINDER_OUT, W'(0));
    RST = 1'b1;
    @(posedge CLK); #1;

    op("udiv", 8'd100, 8'd7, 1'b0, W + 2, 8'd14, 8'd2, 1'b0);
    op("sdiv_neg_a", 8'hF9, 8'h02, 1'b1, W + 2, 8'hFD, 8'hFF, 1'b0);
    op("sdiv_neg_b", 8'h07, 8'hFE, 1'b1, W + 2, 8'hFD, 8'h01, 1'b0);
    op("div0_u", 8'h55, 8'h00, 1'b0, 1, 8'hFF, 8'h55, 1'b1);
    op("div0_s", 8'h55, 8'h00, 1'b1, 1, 8'hFF, 8'h55, 1'b1);
    op("sovf", 8'h80, 8'hFF, 1'b1, W + 2, 8'h80, 8'h00, 1'b1);
    op("sovf_unsigned", 8'h80, 8'hFF, 1'b0, W + 2, 8'h00, 8'h80, 1'b0);

    // START held through an operation while the operands keep changing.
    bus.START       = 1'b1;
    bus.DATA_A_IN   = 8'd100;
    bus.DATA_B_IN   = 8'd7;
    bus.SIGNED_MODE = 1'b0;
    @(posedge CLK); #1;
    n = 0;
    while (!bus.READY && n < 40) begin
      bus.DATA_A_IN   = W'($urandom);
      bus.DATA_B_IN   = W'($urandom);
      bus.SIGNED_MODE = 1'($urandom);
      @(posedge CLK); #1;
      n++;
    end
    chk("held_latency", W'(n), W'(W + 2));
    chk("held_q", bus.DATA_OUT, 8'd14);
    chk("held_r", bus.REMAINDER_OUT, 8'd2);
    @(posedge CLK); #1;
    bus.START = 1'b0;
    chk("b2b_accepted", W'(bus.BUSY), W'(1));
    n = 0;
    while (!bus.READY && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("b2b_completed", W'(n < 40), W'(1));
    @(posedge CLK); #1;

    // Asynchronous reset in the middle of an operation.
    bus.START     = 1'b1;
    bus.DATA_A_IN = 8'd200;
    bus.DATA_B_IN = 8'd3;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("midreset_busy", W'(bus.BUSY), W'(0));
    chk("midreset_ready", W'(bus.READY), W'(0));
    chk("midreset_q", bus.DATA_OUT, W'(0));
    chk("midreset_r", bus.REMAINDER_OUT, W'(0));
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (bus.READY) n++;
    end
    chk("midreset_no_ready", W'(n), W'(0));
    op("after_reset", 8'd255, 8'd1, 1'b0, W + 2, 8'd255, 8'd0, 1'b0);

    // Random traffic, with occasional reset pulses; the compare process checks.
    for (int i = 0; i < 3000; i++) begin
      bus.START       = ($urandom_range(0, 3) == 0);
      bus.SIGNED_MODE = 1'($urandom);
      bus.DATA_A_IN   = W'($urandom);
      bus.DATA_B_IN   = W'($urandom);
      case ($urandom_range(0, 15))
        0: bus.DATA_B_IN = '0;
        1: begin
          bus.DATA_A_IN = 8'h80;
          bus.DATA_B_IN = 8'hFF;
        end
        2: bus.DATA_B_IN = 8'd1;
        3: bus.DATA_A_IN = bus.DATA_B_IN;
        default: ;
      endcase
      RST = ($urandom_range(0, 299) != 0);
      @(posedge CLK); #1;
    end
    RST       = 1'b1;
    bus.START = 1'b0;
    n = 0;
    while (bus.BUSY && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("final_idle", W'(bus.BUSY), W'(0));
    repeat (2) @(posedge CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/model_scalar_integer_divider_iterative.md
Name: model_scalar_integer_divider_iterative

Overview:
Parametrised multi-cycle integer divider computing quotient and remainder, one restoring-division bit per clock.
Runtime-selectable signed or unsigned mode, with divide-by-zero and signed-overflow detection.
Successor to the single-step scalar integer divider in the arithmetic/integer/scalar library; same START/READY handshake, so NTM vector and matrix wrappers can instantiate it directly.

Parameters:
DATA_SIZE, 64, operand, quotient and remainder width in bits (>=2).
CONTROL_SIZE, 4, reserved for library-wide uniformity; unused inside the block.

Ports:
CLK  input  1  clock, all state updates on rising edge.
RST  input  1  asynchronous, active-low reset; clears all state while low.
START  input  1  request; sampled only in IDLE.
SIGNED_MODE  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
DATA_A_IN  input  DATA_SIZE  dividend.
DATA_B_IN  input  DATA_SIZE  divisor.
READY  output  1  one-cycle pulse; results valid.
BUSY  output  1  high from the START-sampling edge until the edge that raises READY.
DATA_OUT  output  DATA_SIZE  quotient.
REMAINDER_OUT  output  DATA_SIZE  remainder.
OVERFLOW_OUT  output  1  divide-by-zero or signed overflow; valid with READY.

Behaviour:
- Reset (RST low, any state, any time): all outputs 0, internal registers 0, state IDLE. An operation in flight is discarded; no READY.
- States: IDLE, LOAD, ITERATE, FIX.
- IDLE:
  - READY and OVERFLOW_OUT drive 0 every cycle.
  - START=1: latch A, B and SIGNED_MODE; BUSY<=1; go to LOAD.
- LOAD, edge +1:
  - Divide by zero (B==0): DATA_OUT<=all ones; REMAINDER_OUT<=A unchanged; OVERFLOW_OUT<=1; READY<=1; BUSY<=0; go to IDLE.
  - Otherwise: take magnitudes (absolute value only when signed and MSB set), record quotient sign (sign A XOR sign B) and remainder sign (sign A), clear the partial remainder, set the counter to DATA_SIZE-1, go to ITERATE.
- ITERATE, edges +2 .. +DATA_SIZE+1, one step per edge:
  - Shift the partial remainder left and bring in the next dividend MSB.
  - Trial-subtract |B| at DATA_SIZE+1 bits.
  - Non-negative result: keep it and shift a quotient bit of 1; otherwise shift a 0.
  - Counter decrements; on the step with counter==0, go to FIX.
- FIX, edge +DATA_SIZE+2:
  - Negate the quotient and/or remainder per the recorded signs (truncation toward zero; remainder sign follows the dividend; zero remainder stays 0).
  - Drive DATA_OUT and REMAINDER_OUT; READY<=1; BUSY<=0; go to IDLE.
  - Signed overflow (A = most-negative, B = -1): OVERFLOW_OUT<=1, DATA_OUT = most-negative value, REMAINDER_OUT = 0.
- Latency: READY is high in the cycle after edge +DATA_SIZE+2 (normal) or after edge +1 (divide by zero). Exactly one READY per accepted START.
- DATA_OUT and REMAINDER_OUT hold their values until the next completion. OVERFLOW_OUT returns to 0 in IDLE.
- START while BUSY: ignored, never queued. START in the READY cycle (state IDLE) is accepted, giving back-to-back operation.
- Input changes after the START-sampling edge have no effect on the operation in flight.
- Unsigned mode: operands treated as magnitudes; no sign fix-up; overflow only on divide by zero.

Test Plan (DATA_SIZE=8):
1. Unsigned: A=100, B=7, START at edge 0 -> READY after edge 10; DATA_OUT=14, REMAINDER_OUT=2, OVERFLOW_OUT=0; BUSY high for edges 0..9.
2. Signed: A=0xF9 (-7), B=0x02 -> DATA_OUT=0xFD (-3), REMAINDER_OUT=0xFF (-1). A=0x07, B=0xFE -> 0xFD and 0x01.
3. Divide by zero: A=0x55, B=0, either mode -> READY after edge 1; DATA_OUT=0xFF, REMAINDER_OUT=0x55, OVERFLOW_OUT=1; next IDLE cycle OVERFLOW_OUT=0.
4. Signed overflow: A=0x80, B=0xFF -> DATA_OUT=0x80, REMAINDER_OUT=0, OVERFLOW_OUT=1. Same operands unsigned -> DATA_OUT=0, REMAINDER_OUT=0x80, OVERFLOW_OUT=0.
5. Handshake: START held high through operation 1 with operands changed mid-flight -> single result 14/2. START in the READY cycle -> second operation accepted immediately.
6. RST low at edge 5 of an operation -> outputs 0, BUSY=0, no READY. Release RST and divide 255 by 1 -> DATA_OUT=255, REMAINDER_OUT=0.
